// File: rtl/bfg_mux_sweep_checker.sv
// Exhaustive data/select sweep of a BFG-generated vs standard-cell N:1 mux pair with per-mux mismatch counting.
// Define BFG_MUX_SYNC_EN to pass both mux returns through 2-flop synchronisers (adds 2 cycles per vector).
`timescale 1ns/1ps

module bfg_mux_sweep_checker #(
  parameter int NUM_INPUTS    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                                          wb_clk_i,
  input  logic                                          wb_rst_ni,
  input  logic                                          start_i,
  output logic [NUM_INPUTS-1:0]                         mux_in_o,
  output logic [$clog2(NUM_INPUTS)-1:0]                 mux_sel_o,
  input  logic                                          bfg_out_i,
  input  logic                                          gf_out_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          pass_o,
  output logic [CNT_W-1:0]                              bfg_err_cnt_o,
  output logic [CNT_W-1:0]                              gf_err_cnt_o,
  output logic                                          first_fail_valid_o,
  output logic [NUM_INPUTS+$clog2(NUM_INPUTS)-1:0]      first_fail_idx_o
);

  localparam int SEL_W = $clog2(NUM_INPUTS);
  localparam int IDX_W = NUM_INPUTS + SEL_W;
`ifdef BFG_MUX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int HOLD = SETTLE_CYCLES + SYNC_LAT;
  localparam int SC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  // Bit 0 carries the BFG return, bit 1 the standard-cell return.
  logic [1:0] ret_raw;
  logic [1:0] ret_smp;
  assign ret_raw = {gf_out_i, bfg_out_i};

`ifdef BFG_MUX_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= ret_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign ret_smp[gi] = sync_reg;
    end
  endgenerate
`else
  assign ret_smp = ret_raw;
`endif

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [SC_W-1:0]    settle_reg;
  logic [CNT_W-1:0]   bfg_cnt_reg;
  logic [CNT_W-1:0]   gf_cnt_reg;
  logic               ff_valid_reg;
  logic [IDX_W-1:0]   ff_idx_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               pass_reg;

  logic [NUM_INPUTS-1:0] data_vec;
  logic [SEL_W-1:0]      sel_vec;
  logic                  exp_bit;
  logic                  bfg_mis;
  logic                  gf_mis;
  logic [CNT_W-1:0]      bfg_cnt_next;
  logic [CNT_W-1:0]      gf_cnt_next;

  // The expected bit comes from the registered vector, so it is stable across the whole period.
  always_comb begin
    data_vec     = idx_reg[IDX_W-1:SEL_W];
    sel_vec      = idx_reg[SEL_W-1:0];
    exp_bit      = data_vec[sel_vec];
    bfg_mis      = ret_smp[0] ^ exp_bit;
    gf_mis       = ret_smp[1] ^ exp_bit;
    bfg_cnt_next = bfg_cnt_reg;
    gf_cnt_next  = gf_cnt_reg;
    if (bfg_mis && (bfg_cnt_reg != CNT_MAX)) bfg_cnt_next = bfg_cnt_reg + CNT_W'(1);
    if (gf_mis && (gf_cnt_reg != CNT_MAX))   gf_cnt_next  = gf_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      settle_reg   <= '0;
      bfg_cnt_reg  <= '0;
      gf_cnt_reg   <= '0;
      ff_valid_reg <= 1'b0;
      ff_idx_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      pass_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_reg    <= S_APPLY;
            idx_reg      <= '0;
            settle_reg   <= '0;
            bfg_cnt_reg  <= '0;
            gf_cnt_reg   <= '0;
            ff_valid_reg <= 1'b0;
            ff_idx_reg   <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            pass_reg     <= 1'b0;
          end
        end
        S_APPLY: begin
          if (settle_reg == SC_LAST) state_reg <= S_CHECK;
          else                       settle_reg <= settle_reg + SC_W'(1);
        end
        S_CHECK: begin
          bfg_cnt_reg <= bfg_cnt_next;
          gf_cnt_reg  <= gf_cnt_next;
          // A vector failing on both muxes still latches its index only once.
          if (!ff_valid_reg && (bfg_mis || gf_mis)) begin
            ff_valid_reg <= 1'b1;
            ff_idx_reg   <= idx_reg;
          end
          if (idx_reg == IDX_LAST) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            pass_reg  <= (bfg_cnt_next == '0) && (gf_cnt_next == '0);
          end else begin
            state_reg  <= S_APPLY;
            idx_reg    <= idx_reg + IDX_W'(1);
            settle_reg <= '0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mux_in_o           = idx_reg[IDX_W-1:SEL_W];
  assign mux_sel_o          = idx_reg[SEL_W-1:0];
  assign busy_o             = busy_reg;
  assign done_o             = done_reg;
  assign pass_o             = pass_reg;
  assign bfg_err_cnt_o      = bfg_cnt_reg;
  assign gf_err_cnt_o       = gf_cnt_reg;
  assign first_fail_valid_o = ff_valid_reg;
  assign first_fail_idx_o   = ff_idx_reg;

endmodule

// File: tb/tb_bfg_mux_sweep_checker.sv
// Directed bench: a 16-bit-counter checker with configurable return faults, and a 4-bit-counter checker with an inverted standard-cell return.
`timescale 1ns/1ps

module tb_bfg_mux_sweep_checker;
  localparam int N      = 4;
  localparam int S      = 2;
  localparam int IW     = N + S;
  localparam int V      = 64;
  localparam int SETTLE = 2;
`ifdef BFG_MUX_SYNC_EN
  localparam int P = SETTLE + 3;
`else
  localparam int P = SETTLE + 1;
`endif

  typedef struct {
    int lat;
    int bfg;
    int gf;
    int ffv;
    int ffi;
    int pas;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  int   mode;  // 0 ideal, 1 bfg stuck at 0, 2 gf inverted

  logic [N-1:0]  m_in;
  logic [S-1:0]  m_sel;
  logic          m_bfg, m_gf, m_busy, m_done, m_pass, m_ffv;
  logic [15:0]   m_bcnt, m_gcnt;
  logic [IW-1:0] m_ffi;

  logic [N-1:0]  s_in;
  logic [S-1:0]  s_sel;
  logic          s_bfg, s_gf, s_busy, s_done, s_pass, s_ffv;
  logic [3:0]    s_bcnt, s_gcnt;
  logic [IW-1:0] s_ffi;

  assign m_bfg = (mode == 1) ? 1'b0 : m_in[m_sel];
  assign m_gf  = (mode == 2) ? ~m_in[m_sel] : m_in[m_sel];
  assign s_bfg = s_in[s_sel];
  assign s_gf  = ~s_in[s_sel];

  bfg_mux_sweep_checker #(.NUM_INPUTS(N), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
    .mux_in_o(m_in), .mux_sel_o(m_sel), .bfg_out_i(m_bfg), .gf_out_i(m_gf),
    .busy_o(m_busy), .done_o(m_done), .pass_o(m_pass),
    .bfg_err_cnt_o(m_bcnt), .gf_err_cnt_o(m_gcnt),
    .first_fail_valid_o(m_ffv), .first_fail_idx_o(m_ffi)
  );

  bfg_mux_sweep_checker #(.NUM_INPUTS(N), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut_sat (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
    .mux_in_o(s_in), .mux_sel_o(s_sel), .bfg_out_i(s_bfg), .gf_out_i(s_gf),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass),
    .bfg_err_cnt_o(s_bcnt), .gf_err_cnt_o(s_gcnt),
    .first_fail_valid_o(s_ffv), .first_fail_idx_o(s_ffi)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_m[$];
  exp_t sb_s[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: walks every vector and applies the return fault of the given mode.
  function automatic exp_t model(input int md, input int cw, input int lat);
    exp_t          e;
    logic [IW-1:0] vv;
    logic [N-1:0]  d;
    logic [S-1:0]  sl;
    logic          b, bo, go;
    int            maxc;
    maxc  = (1 << cw) - 1;
    e.lat = lat; e.bfg = 0; e.gf = 0; e.ffv = 0; e.ffi = 0; e.pas = 0;
    for (int v = 0; v < V; v++) begin
      vv = v[IW-1:0];
      d  = vv[IW-1:S];
      sl = vv[S-1:0];
      b  = d[sl];
      bo = (md == 1) ? 1'b0 : b;
      go = (md == 2) ? ~b : b;
      if (bo !== b && e.bfg < maxc) e.bfg++;
      if (go !== b && e.gf < maxc)  e.gf++;
      if ((bo !== b || go !== b) && e.ffv == 0) begin
        e.ffv = 1;
        e.ffi = v;
      end
    end
    e.pas = (e.bfg == 0 && e.gf == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_m_vec"},  {m_in, m_sel}, 0);
    chk({tag, "_m_busy"}, m_busy, 0);
    chk({tag, "_m_done"}, m_done, 0);
    chk({tag, "_m_pass"}, m_pass, 0);
    chk({tag, "_m_bcnt"}, m_bcnt, 0);
    chk({tag, "_m_gcnt"}, m_gcnt, 0);
    chk({tag, "_m_ffv"},  m_ffv, 0);
    chk({tag, "_m_ffi"},  m_ffi, 0);
    chk({tag, "_s_vec"},  {s_in, s_sel}, 0);
    chk({tag, "_s_busy"}, s_busy, 0);
    chk({tag, "_s_done"}, s_done, 0);
    chk({tag, "_s_gcnt"}, s_gcnt, 0);
  endtask

  // Start is driven for 'hold' rising edges; results are checked when done_o rises.
  task automatic run_sweep(input string tag, input int hold);
    exp_t em, es;
    int   n, seq_err, lim;
    sb_m.push_back(model(mode, 16, V * P));
    sb_s.push_back(model(2, 4, V * P));
    lim     = V * P + 20;
    seq_err = 0;
    start   = 1'b1;
    @(negedge clk);
    n = 0;
    chk({tag, "_start_busy"}, {m_busy, s_busy, m_done, s_done}, 4'b1100);
    chk({tag, "_start_clear"}, {m_bcnt, m_gcnt, 12'h0, s_gcnt, 3'b0, m_ffv}, 0);
    while (1) begin
      if (m_done === 1'b1 || n > lim) break;
      if ({m_in, m_sel} !== IW'(n / P) || {s_in, s_sel} !== IW'(n / P) || m_busy !== 1'b1)
        seq_err++;
      if (n + 1 >= hold) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    em = sb_m.pop_front();
    es = sb_s.pop_front();
    chk({tag, "_latency"}, n, em.lat);
    chk({tag, "_seq"},     seq_err, 0);
    chk({tag, "_m_busy"},  m_busy, 0);
    chk({tag, "_m_pass"},  m_pass, em.pas);
    chk({tag, "_m_bcnt"},  m_bcnt, em.bfg);
    chk({tag, "_m_gcnt"},  m_gcnt, em.gf);
    chk({tag, "_m_ffv"},   m_ffv, em.ffv);
    chk({tag, "_m_ffi"},   m_ffi, em.ffi);
    chk({tag, "_s_done"},  s_done, 1);
    chk({tag, "_s_pass"},  s_pass, es.pas);
    chk({tag, "_s_bcnt"},  s_bcnt, es.bfg);
    chk({tag, "_s_gcnt"},  s_gcnt, es.gf);
    chk({tag, "_s_ffv"},   s_ffv, es.ffv);
    chk({tag, "_s_ffi"},   s_ffi, es.ffi);
    repeat (4) @(negedge clk);
    chk({tag, "_hold_done"}, {m_done, m_busy}, 2'b10);
    chk({tag, "_hold_cnt"},  {m_bcnt, m_gcnt}, {em.bfg[15:0], em.gf[15:0]});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("idle");

    mode = 0;
    run_sweep("ideal", 1);
    mode = 1;
    run_sweep("bfg_stuck0", 1);
    // Start held high while DONE: must restart with the previous 32 mismatches cleared.
    mode = 0;
    run_sweep("held_restart", 3);

    // Second start mid-sweep is ignored; reset at cycle 100 aborts everything.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (n == 99) begin
        chk("abort_idx",  {m_in, m_sel}, 99 / P);
        chk("abort_busy", m_busy, 1);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check_reset("abort_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("abort_idle");

    mode = 0;
    run_sweep("after_abort", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
